boot_seq_ctrl: RTL and testbench

Power-up and reset sequencer for the Xilinx Cheshire top level. It watches the clock wizard lock and the DRAM MIG calibration status, and runs the reset release order: DRAM controller first, then SoC and USB. It latches the boot mode at SoC reset release and supports a software/VIO-triggered SoC-only reset. It sits between the clock/reset inputs and the `rstgen`, `dram_wrapper_xilinx` and `cheshire_soc` instances, in the `soc_clk` domain.

---
 rtl/boot_seq_ctrl_if.sv | 40 ++++
 rtl/boot_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_boot_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_seq_ctrl_if.sv
// Signal bundle between the boot sequencer and the clock/reset, DRAM and SoC side.
// The slave modport belongs to the sequencer and the master modport to whatever drives it.
interface boot_seq_ctrl_if;
  logic       pll_locked_i;
  logic       dram_calib_done_i;
  logic       sw_rst_req_i;
  logic [1:0] boot_mode_i;
  logic       dram_rst_o;
  logic       soc_rst_no;
  logic       usb_rst_no;
  logic [1:0] boot_mode_o;
  logic       calib_err_o;
  logic [2:0] state_o;

  modport slave (
    input  pll_locked_i,
    input  dram_calib_done_i,
    input  sw_rst_req_i,
    input  boot_mode_i,
    output dram_rst_o,
    output soc_rst_no,
    output usb_rst_no,
    output boot_mode_o,
    output calib_err_o,
    output state_o
  );

  modport master (
    output pll_locked_i,
    output dram_calib_done_i,
    output sw_rst_req_i,
    output boot_mode_i,
    input  dram_rst_o,
    input  soc_rst_no,
    input  usb_rst_no,
    input  boot_mode_o,
    input  calib_err_o,
    input  state_o
  );
endinterface

// File: rtl/boot_seq_ctrl.sv
// Power-up sequencer: filters PLL lock, pulses the DRAM reset, waits for calibration,
// then releases SoC/USB reset and latches the boot mode. All outputs decode from flops.
module boot_seq_ctrl #(
  parameter int unsigned LockFilter    = 8,
  parameter int unsigned DramRstCycles = 16,
  parameter int unsigned SocRstCycles  = 32,
  parameter int unsigned CalibTimeout  = 1048576
) (
  input  logic           clk_i,
  input  logic           rst_i,
  boot_seq_ctrl_if.slave bus
);
  localparam int unsigned MaxLd     = (LockFilter > DramRstCycles) ? LockFilter : DramRstCycles;
  localparam int unsigned MaxSc     = (SocRstCycles > CalibTimeout) ? SocRstCycles : CalibTimeout;
  localparam int unsigned MaxCycles = (MaxLd > MaxSc) ? MaxLd : MaxSc;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DRAM_RST   = 3'd1,
    WAIT_CALIB = 3'd2,
    SOC_RST    = 3'd3,
    RUN        = 3'd4,
    ERROR      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      lock_sync_q, lock_sync_d;
  logic [1:0]      calib_sync_q, calib_sync_d;
  logic [1:0]      boot_mode_q, boot_mode_d;
  logic            calib_err_q, calib_err_d;
  logic            recal_q, recal_d;

  logic lock_s;
  logic calib_s;
  logic lock_done;
  logic dram_done;
  logic calib_expired;
  logic soc_done;

  assign lock_s  = lock_sync_q[1];
  assign calib_s = calib_sync_q[1];

  // Terminal counts: a state that waits N cycles leaves when the counter shows N-1.
  assign lock_done     = (cnt_q == CntW'(LockFilter - 1));
  assign dram_done     = (cnt_q == CntW'(DramRstCycles - 1));
  assign calib_expired = (cnt_q == CntW'(CalibTimeout - 1));
  assign soc_done      = (cnt_q == CntW'(SocRstCycles - 1));

  always_comb begin
    lock_sync_d  = {lock_sync_q[0], bus.pll_locked_i};
    calib_sync_d = {calib_sync_q[0], bus.dram_calib_done_i};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    boot_mode_d = boot_mode_q;
    calib_err_d = calib_err_q;
    recal_d     = recal_q;

    case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (lock_done) begin
          state_d = DRAM_RST;
        end
      end
      DRAM_RST: begin
        if (dram_done) begin
          state_d = WAIT_CALIB;
        end
      end
      WAIT_CALIB: begin
        if (calib_s) begin
          state_d = SOC_RST;
        end else if (calib_expired) begin
          state_d     = ERROR;
          calib_err_d = 1'b1;
        end
      end
      SOC_RST: begin
        // A held software request parks here; the full count restarts on release.
        if (bus.sw_rst_req_i) begin
          cnt_d = '0;
        end else if (recal_q) begin
          state_d = DRAM_RST;
          recal_d = 1'b0;
        end else if (soc_done) begin
          state_d     = RUN;
          boot_mode_d = bus.boot_mode_i;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (bus.sw_rst_req_i) begin
          state_d = SOC_RST;
        end else if (!calib_s) begin
          state_d = SOC_RST;
          recal_d = 1'b1;
        end
      end
      ERROR: begin
        cnt_d = '0;
        if (bus.sw_rst_req_i) begin
          state_d     = DRAM_RST;
          calib_err_d = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Losing the clock overrides everything, including a pending software request.
    if ((state_q != WAIT_LOCK) && !lock_s) begin
      state_d = WAIT_LOCK;
      recal_d = 1'b0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      lock_sync_q  <= '0;
      calib_sync_q <= '0;
      boot_mode_q  <= '0;
      calib_err_q  <= 1'b0;
      recal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_sync_q  <= lock_sync_d;
      calib_sync_q <= calib_sync_d;
      boot_mode_q  <= boot_mode_d;
      calib_err_q  <= calib_err_d;
      recal_q      <= recal_d;
    end
  end

  assign bus.dram_rst_o  = (state_q == WAIT_LOCK) || (state_q == DRAM_RST);
  assign bus.soc_rst_no  = (state_q == RUN);
  assign bus.usb_rst_no  = (state_q == RUN);
  assign bus.boot_mode_o = boot_mode_q;
  assign bus.calib_err_o = calib_err_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Self-checking bench for boot_seq_ctrl: expected edge numbers come from the sequencing
// rules (sync latency, filter length, hold lengths) applied to the driven stimulus.
module tb_boot_seq_ctrl;
  localparam int LF = 8;
  localparam int DR = 16;
  localparam int SR = 32;
  localparam int CT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n;
  logic [1:0] exp_bm;

  boot_seq_ctrl_if bif();

  boot_seq_ctrl #(
    .LockFilter(LF), .DramRstCycles(DR), .SocRstCycles(SR), .CalibTimeout(CT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Reference: pll first sampled high (and staying high) at edge f -> FSM sees it at f+2,
  // DRAM reset entered after LF samples, then DR hold, 1 calib cycle, SR hold.
  function automatic int dram_fall_edge(input int first_high);
    return first_high + 2 + LF - 1 + DR;
  endfunction

  function automatic int soc_rise_edge(input int first_high);
    return dram_fall_edge(first_high) + 1 + SR;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic pll, input logic calib);
    rst = 1'b1;
    bif.pll_locked_i      = pll;
    bif.dram_calib_done_i = calib;
    bif.sw_rst_req_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_dram_fall(input int limit, output int e);
    e = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bif.dram_rst_o === 1'b0) begin
        e = edge_n;
        break;
      end
    end
  endtask

  task automatic wait_soc_rise(input int limit, output int e);
    e = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bif.soc_rst_no === 1'b1) begin
        e = edge_n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.pll_locked_i = 1'b0; bif.dram_calib_done_i = 1'b0;
    bif.sw_rst_req_i = 1'b0; bif.boot_mode_i = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bif.dram_rst_o !== 1'b1) begin miscompares++; $display("FAIL reset_dram_rst got=%b exp=1", bif.dram_rst_o); end
    vectors++; if (bif.soc_rst_no !== 1'b0) begin miscompares++; $display("FAIL reset_soc_rst_n got=%b exp=0", bif.soc_rst_no); end
    vectors++; if (bif.usb_rst_no !== 1'b0) begin miscompares++; $display("FAIL reset_usb_rst_n got=%b exp=0", bif.usb_rst_no); end
    vectors++; if (bif.boot_mode_o !== 2'b00) begin miscompares++; $display("FAIL reset_boot_mode got=%b exp=00", bif.boot_mode_o); end
    vectors++; if (bif.calib_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_calib_err got=%b exp=0", bif.calib_err_o); end
    vectors++; if (bif.state_o !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", bif.state_o); end
    $display("reset: outputs sampled while rst high");
  endtask

  task automatic test_nominal();
    int e1, e2;
    exp_bm = 2'($urandom_range(0, 3));
    bif.boot_mode_i = exp_bm;
    start_seq(1'b1, 1'b1);
    wait_dram_fall(100, e1);
    vectors++; if (e1 !== dram_fall_edge(1)) begin miscompares++; $display("FAIL nominal_dram_fall got=%0d exp=%0d", e1, dram_fall_edge(1)); end
    vectors++; if (bif.state_o !== 3'd2) begin miscompares++; $display("FAIL nominal_wait_calib got=%0d exp=2", bif.state_o); end
    step();
    vectors++; if (bif.state_o !== 3'd3) begin miscompares++; $display("FAIL nominal_soc_rst_state got=%0d exp=3", bif.state_o); end
    wait_soc_rise(100, e2);
    vectors++; if (e2 !== soc_rise_edge(1)) begin miscompares++; $display("FAIL nominal_soc_rise got=%0d exp=%0d", e2, soc_rise_edge(1)); end
    vectors++; if (bif.usb_rst_no !== 1'b1) begin miscompares++; $display("FAIL nominal_usb got=%b exp=1", bif.usb_rst_no); end
    vectors++; if (bif.state_o !== 3'd4) begin miscompares++; $display("FAIL nominal_state_run got=%0d exp=4", bif.state_o); end
    vectors++; if (bif.boot_mode_o !== exp_bm) begin miscompares++; $display("FAIL nominal_boot_mode got=%b exp=%b", bif.boot_mode_o, exp_bm); end
    vectors++; if (bif.dram_rst_o !== 1'b0 || bif.calib_err_o !== 1'b0) begin miscompares++; $display("FAIL nominal_run_flags got dram=%b err=%b exp 0/0", bif.dram_rst_o, bif.calib_err_o); end
    $display("nominal: bm=%b dram_fall=%0d soc_rise=%0d", exp_bm, e1, e2);
  endtask

  task automatic test_lock_glitch(input int g);
    int e1, e2;
    exp_bm = 2'($urandom_range(0, 3));
    bif.boot_mode_i = exp_bm;
    start_seq(1'b1, 1'b1);
    for (int k = 1; k <= g; k++) begin
      if (k == g) bif.pll_locked_i = 1'b0;
      step();
    end
    bif.pll_locked_i = 1'b1;
    wait_dram_fall(200, e1);
    vectors++; if (e1 !== dram_fall_edge(g + 1)) begin miscompares++; $display("FAIL glitch_dram_fall g=%0d got=%0d exp=%0d", g, e1, dram_fall_edge(g + 1)); end
    wait_soc_rise(200, e2);
    vectors++; if (e2 !== soc_rise_edge(g + 1)) begin miscompares++; $display("FAIL glitch_soc_rise g=%0d got=%0d exp=%0d", g, e2, soc_rise_edge(g + 1)); end
    $display("lock_glitch: edge=%0d dram_fall=%0d soc_rise=%0d", g, e1, e2);
  endtask

  task automatic test_calib_timeout();
    int e1, e2, x, r, guard;
    exp_bm = 2'($urandom_range(0, 3));
    bif.boot_mode_i = exp_bm;
    start_seq(1'b1, 1'b0);
    wait_dram_fall(100, e1);
    vectors++; if (e1 !== dram_fall_edge(1)) begin miscompares++; $display("FAIL timeout_dram_fall got=%0d exp=%0d", e1, dram_fall_edge(1)); end
    guard = 0;
    while (edge_n < e1 + CT - 1 && guard < 2 * CT) begin
      step();
      guard++;
    end
    vectors++; if (bif.state_o !== 3'd2 || bif.calib_err_o !== 1'b0) begin miscompares++; $display("FAIL timeout_before state=%0d err=%b exp 2/0", bif.state_o, bif.calib_err_o); end
    step();
    vectors++; if (bif.state_o !== 3'd5) begin miscompares++; $display("FAIL timeout_error_state got=%0d exp=5 edge=%0d", bif.state_o, edge_n); end
    vectors++; if (bif.calib_err_o !== 1'b1) begin miscompares++; $display("FAIL timeout_err_flag got=%b exp=1", bif.calib_err_o); end
    vectors++; if (bif.soc_rst_no !== 1'b0 || bif.dram_rst_o !== 1'b0) begin miscompares++; $display("FAIL timeout_outputs soc=%b dram=%b exp 0/0", bif.soc_rst_no, bif.dram_rst_o); end
    bif.dram_calib_done_i = 1'b1;
    r = $urandom_range(3, 20);
    repeat (r - 1) step();
    bif.sw_rst_req_i = 1'b1;
    step();
    x = edge_n;
    bif.sw_rst_req_i = 1'b0;
    vectors++; if (bif.state_o !== 3'd1 || bif.calib_err_o !== 1'b0 || bif.dram_rst_o !== 1'b1) begin miscompares++; $display("FAIL retry_entry state=%0d err=%b dram=%b exp 1/0/1", bif.state_o, bif.calib_err_o, bif.dram_rst_o); end
    wait_soc_rise(200, e2);
    vectors++; if (e2 !== x + DR + 1 + SR) begin miscompares++; $display("FAIL retry_soc_rise got=%0d exp=%0d", e2, x + DR + 1 + SR); end
    vectors++; if (bif.state_o !== 3'd4 || bif.boot_mode_o !== exp_bm) begin miscompares++; $display("FAIL retry_run state=%0d bm=%b exp 4/%b", bif.state_o, bif.boot_mode_o, exp_bm); end
    $display("calib_timeout: wait_calib=%0d retry_edge=%0d soc_rise=%0d", e1, x, e2);
  endtask

  task automatic test_sw_reset();
    int x, h, e, dram_seen;
    logic [1:0] nbm, pre_bm;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(1, 4)) step();
      h   = $urandom_range(1, 4);
      nbm = (i == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      bif.boot_mode_i  = exp_bm;
      bif.sw_rst_req_i = 1'b1;
      step();
      x = edge_n;
      vectors++; if (bif.soc_rst_no !== 1'b0) begin miscompares++; $display("FAIL sw_enter soc=%b exp=0", bif.soc_rst_no); end
      repeat (h - 1) step();
      bif.sw_rst_req_i = 1'b0;
      bif.boot_mode_i  = nbm;
      dram_seen = 0;
      e = -1;
      pre_bm = bif.boot_mode_o;
      for (int k = 0; k < 100; k++) begin
        if (bif.soc_rst_no !== 1'b1) pre_bm = bif.boot_mode_o;
        step();
        if (bif.dram_rst_o !== 1'b0) dram_seen++;
        if (bif.soc_rst_no === 1'b1) begin
          e = edge_n;
          break;
        end
      end
      vectors++; if (e !== x + h - 1 + SR) begin miscompares++; $display("FAIL sw_release hold=%0d got=%0d exp=%0d", h, e, x + h - 1 + SR); end
      vectors++; if (dram_seen !== 0) begin miscompares++; $display("FAIL sw_dram_stays_low got=%0d exp=0 cycles high", dram_seen); end
      vectors++; if (pre_bm !== exp_bm) begin miscompares++; $display("FAIL sw_bm_before got=%b exp=%b", pre_bm, exp_bm); end
      vectors++; if (bif.boot_mode_o !== nbm) begin miscompares++; $display("FAIL sw_bm_after got=%b exp=%b", bif.boot_mode_o, nbm); end
      $display("sw_reset: req_edge=%0d hold=%0d release=%0d bm=%b", x, h, e, nbm);
      exp_bm = nbm;
    end
  endtask

  task automatic test_lock_lost();
    int l, r, e1, e2;
    repeat ($urandom_range(1, 4)) step();
    bif.pll_locked_i = 1'b0;
    l = edge_n;
    step();
    step();
    vectors++; if (bif.soc_rst_no !== 1'b1) begin miscompares++; $display("FAIL lock_lost_early soc=%b exp=1 at edge %0d", bif.soc_rst_no, edge_n); end
    step();
    vectors++; if (bif.dram_rst_o !== 1'b1 || bif.soc_rst_no !== 1'b0 || bif.usb_rst_no !== 1'b0) begin miscompares++; $display("FAIL lock_lost_3edges dram=%b soc=%b usb=%b exp 1/0/0", bif.dram_rst_o, bif.soc_rst_no, bif.usb_rst_no); end
    vectors++; if (bif.state_o !== 3'd0) begin miscompares++; $display("FAIL lock_lost_state got=%0d exp=0", bif.state_o); end
    repeat ($urandom_range(0, 5)) step();
    exp_bm = 2'($urandom_range(1, 3));
    bif.boot_mode_i  = exp_bm;
    bif.pll_locked_i = 1'b1;
    r = edge_n;
    wait_dram_fall(100, e1);
    vectors++; if (e1 !== dram_fall_edge(r + 1)) begin miscompares++; $display("FAIL relock_dram_fall got=%0d exp=%0d", e1, dram_fall_edge(r + 1)); end
    wait_soc_rise(100, e2);
    vectors++; if (e2 !== soc_rise_edge(r + 1)) begin miscompares++; $display("FAIL relock_soc_rise got=%0d exp=%0d", e2, soc_rise_edge(r + 1)); end
    vectors++; if (bif.boot_mode_o !== exp_bm) begin miscompares++; $display("FAIL relock_bm got=%b exp=%b", bif.boot_mode_o, exp_bm); end
    $display("lock_lost: drop_edge=%0d relock_edge=%0d soc_rise=%0d", l, r, e2);
  endtask

  task automatic test_mid_reset();
    int e1, e2;
    bif.sw_rst_req_i = 1'b1;
    step();
    bif.sw_rst_req_i = 1'b0;
    repeat ($urandom_range(2, 20)) step();
    vectors++; if (bif.state_o !== 3'd3) begin miscompares++; $display("FAIL mid_in_soc_rst got=%0d exp=3", bif.state_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (bif.dram_rst_o !== 1'b1 || bif.soc_rst_no !== 1'b0 || bif.usb_rst_no !== 1'b0) begin miscompares++; $display("FAIL mid_async_resets dram=%b soc=%b usb=%b exp 1/0/0", bif.dram_rst_o, bif.soc_rst_no, bif.usb_rst_no); end
    vectors++; if (bif.boot_mode_o !== 2'b00 || bif.calib_err_o !== 1'b0 || bif.state_o !== 3'd0) begin miscompares++; $display("FAIL mid_async_regs bm=%b err=%b state=%0d exp 00/0/0", bif.boot_mode_o, bif.calib_err_o, bif.state_o); end
    exp_bm = 2'($urandom_range(0, 3));
    bif.boot_mode_i = exp_bm;
    start_seq(1'b1, 1'b1);
    wait_dram_fall(100, e1);
    vectors++; if (e1 !== dram_fall_edge(1)) begin miscompares++; $display("FAIL mid_restart_dram got=%0d exp=%0d", e1, dram_fall_edge(1)); end
    wait_soc_rise(100, e2);
    vectors++; if (e2 !== soc_rise_edge(1) || bif.boot_mode_o !== exp_bm) begin miscompares++; $display("FAIL mid_restart_soc got=%0d bm=%b exp=%0d bm=%b", e2, bif.boot_mode_o, soc_rise_edge(1), exp_bm); end
    $display("mid_reset: restart dram_fall=%0d soc_rise=%0d", e1, e2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.pll_locked_i      = 1'b0;
    bif.dram_calib_done_i = 1'b0;
    bif.sw_rst_req_i      = 1'b0;
    bif.boot_mode_i       = 2'b00;
    exp_bm                = 2'b00;
    test_reset();
    test_nominal();
    test_lock_glitch(6);
    test_lock_glitch($urandom_range(1, 8));
    test_lock_glitch($urandom_range(1, 8));
    test_calib_timeout();
    test_sw_reset();
    test_lock_lost();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
